// File: rtl/tv80_dbg_pkg.sv
// Shared constants for the TV80 register-dump debug port.
// Covers frame layout, FSM encoding and checksum helper.
package tv80_dbg_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN   = 9;
  localparam int         IDX_W       = 4;
  localparam int         STATE_W     = 1;

  localparam logic [IDX_W-1:0] IDX_ZERO = 4'd0;
  localparam logic [IDX_W-1:0] IDX_ONE  = 4'd1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
  localparam logic [STATE_W-1:0] ST_SEND = 1'b1;

  // Modulo-256 sum of the payload bytes; the header byte is not covered.
  function automatic logic [7:0] frameCk(input logic [7:0]  seq,
                                         input logic [15:0] bc,
                                         input logic [15:0] de,
                                         input logic [15:0] hl);
    frameCk = seq + bc[15:8] + bc[7:0] + de[15:8] + de[7:0] + hl[15:8] + hl[7:0];
  endfunction

endpackage

// File: rtl/tv80_regdump.sv
// Captures BC/DE/HL on request and streams them out as a 9-byte
// checksummed frame over a valid/ready byte interface.
module tv80_regdump
  import tv80_dbg_pkg::*;
#(
  parameter logic [7:0] HDR = HDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] BC,
  input  logic [15:0] DE,
  input  logic [15:0] HL,
  input  logic        snap,
  input  logic        ovr_clr,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  logic [STATE_W-1:0] stateR, stateNxtS;
  logic [IDX_W-1:0]   idxR, idxNxtS;
  logic [7:0]         seqR, seqNxtS;
  logic [15:0]        bcR, deR, hlR, bcNxtS, deNxtS, hlNxtS;
  logic [7:0]         doutR, byteS, ckS;
  logic               validR, busyR, doneR, overrunR;
  logic               doneNxtS, ovrNxtS, xferS;

  assign xferS = (stateR == ST_SEND) && validR && dout_ready;

  // Next-state, index, sequence, snapshot and overrun decisions.
  always_comb begin
    stateNxtS = stateR;
    idxNxtS   = idxR;
    seqNxtS   = seqR;
    bcNxtS    = bcR;
    deNxtS    = deR;
    hlNxtS    = hlR;
    doneNxtS  = 1'b0;
    case (stateR)
      ST_IDLE: begin
        if (snap) begin
          stateNxtS = ST_SEND;
          idxNxtS   = IDX_ZERO;
          bcNxtS    = BC;
          deNxtS    = DE;
          hlNxtS    = HL;
        end else begin
          stateNxtS = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (xferS && (idxR == IDX_LAST)) begin
          stateNxtS = ST_IDLE;
          idxNxtS   = IDX_ZERO;
          seqNxtS   = seqR + 8'd1;
          doneNxtS  = 1'b1;
        end else if (xferS) begin
          idxNxtS = idxR + IDX_ONE;
        end else begin
          idxNxtS = idxR;
        end
      end
      default: begin
        stateNxtS = ST_IDLE;
        idxNxtS   = IDX_ZERO;
      end
    endcase
    // A dropped snap must win over a simultaneous clear.
    if ((stateR == ST_SEND) && snap) begin
      ovrNxtS = 1'b1;
    end else if (ovr_clr) begin
      ovrNxtS = 1'b0;
    end else begin
      ovrNxtS = overrunR;
    end
  end

  // Byte select for the index that will be presented after this edge.
  always_comb begin
    ckS = frameCk(seqNxtS, bcNxtS, deNxtS, hlNxtS);
    case (idxNxtS)
      4'd0:    byteS = HDR;
      4'd1:    byteS = seqNxtS;
      4'd2:    byteS = bcNxtS[15:8];
      4'd3:    byteS = bcNxtS[7:0];
      4'd4:    byteS = deNxtS[15:8];
      4'd5:    byteS = deNxtS[7:0];
      4'd6:    byteS = hlNxtS[15:8];
      4'd7:    byteS = hlNxtS[7:0];
      4'd8:    byteS = ckS;
      default: byteS = 8'h00;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateR   <= ST_IDLE;
      idxR     <= IDX_ZERO;
      seqR     <= 8'h00;
      bcR      <= 16'h0000;
      deR      <= 16'h0000;
      hlR      <= 16'h0000;
      doutR    <= 8'h00;
      validR   <= 1'b0;
      busyR    <= 1'b0;
      doneR    <= 1'b0;
      overrunR <= 1'b0;
    end else begin
      stateR   <= stateNxtS;
      idxR     <= idxNxtS;
      seqR     <= seqNxtS;
      bcR      <= bcNxtS;
      deR      <= deNxtS;
      hlR      <= hlNxtS;
      doutR    <= (stateNxtS == ST_SEND) ? byteS : 8'h00;
      validR   <= (stateNxtS == ST_SEND);
      busyR    <= (stateNxtS == ST_SEND);
      doneR    <= doneNxtS;
      overrunR <= ovrNxtS;
    end
  end

  assign dout       = doutR;
  assign dout_valid = validR;
  assign busy       = busyR;
  assign done       = doneR;
  assign overrun    = overrunR;

endmodule

// File: doc/tv80_regdump.md
TV80_REGDUMP -- requirements
Module: tv80_regdump

Interface
REQ-001 Parameter HDR, default 8'hA5, frame header byte.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 BC, DE, HL  input  16 each  live register-pair values from the CPU register file.
REQ-005 snap  input  1  capture request, sampled every rising edge.
REQ-006 ovr_clr  input  1  synchronous clear of the overrun flag.
REQ-007 dout  output  8  current frame byte.
REQ-008 dout_valid  output  1  dout holds a valid byte.
REQ-009 dout_ready  input  1  consumer accepts the byte; a transfer occurs on an edge where dout_valid and dout_ready are both high.
REQ-010 busy  output  1  high while a frame is pending or in transfer.
REQ-011 done  output  1  one-cycle pulse after the final byte of a frame transfers.
REQ-012 overrun  output  1  sticky flag: a snap was dropped.

Function
REQ-013 FSM states: IDLE and SEND; busy = (state == SEND).
REQ-014 IDLE with snap=1 at an edge: the block latches BC, DE and HL into a snapshot register, loads byte index 0 and enters SEND; dout_valid is high from the next cycle (latency 1).
REQ-015 Frame, 9 bytes in order: HDR, SEQ, B, C, D, E, H, L, CK.
REQ-016 SEQ is an 8-bit frame counter; it increments on each completed frame, wraps 8'hFF to 8'h00, and is 0 after reset.
REQ-017 CK is the modulo-256 sum of bytes 1..7 (SEQ through L); HDR is excluded.
REQ-018 In SEND, dout_valid stays high continuously, with no bubbles between bytes.
REQ-019 dout shall remain stable while dout_valid=1 and dout_ready=0.
REQ-020 Each transfer advances the byte index by 1, and the next byte appears the following cycle.
REQ-021 A transfer of CK (index 8): next state IDLE, dout_valid=0, done=1 for exactly one cycle, SEQ increments.
REQ-022 The snapshot is frozen for the whole frame; changes on BC/DE/HL during SEND do not affect the frame.
REQ-023 snap=1 in SEND, including the edge where CK transfers, is dropped and sets overrun=1.
REQ-024 snap held high across a CK transfer starts a new frame on the first IDLE edge.
REQ-025 ovr_clr=1 clears overrun; if a drop occurs on the same edge, set wins.
REQ-026 dout_ready has no effect in IDLE.
REQ-027 dout is 8'h00 whenever dout_valid=0.

Reset
REQ-028 reset_n low asynchronously forces: state IDLE, dout=0, dout_valid=0, busy=0, done=0, overrun=0, SEQ=0, byte index=0, snapshot=0.
REQ-029 Reset asserted mid-frame aborts the frame with no done pulse and no SEQ increment; after release, the block waits in IDLE for a new snap.

Structure
REQ-030 Shared package tv80_dbg_pkg holds: the HDR default, frame length constant 9, the state encoding, and the byte-index width (4 bits).
REQ-031 Single flat module, no sub-module; the byte select is a 9-way mux on the index over snapshot, SEQ and CK, with CK computed combinationally from the snapshot and SEQ.

Verification
REQ-032 Basic frame: reset; BC=1234, DE=5678, HL=9ABC; snap pulse; dout_ready held 1 -> bytes A5,00,12,34,56,78,9A,BC,6A on 9 consecutive cycles; done pulse after the last byte; busy high exactly 9 cycles.
REQ-033 Backpressure: same values; dout_ready toggles 1,0,0,1... -> identical byte sequence; dout stable while stalled; no byte skipped or repeated.
REQ-034 Frozen snapshot and SEQ: change HL to FFFF after the header transfers -> H,L bytes remain 9A,BC; a second frame carries SEQ=01 and CK=6B.
REQ-035 Overrun: snap pulse during SEND -> overrun=1 and the frame is unaffected; ovr_clr -> 0; ovr_clr and a dropped snap on the same edge -> overrun stays 1.
REQ-036 Reset mid-frame: reset_n low after byte 3 -> all outputs 0 immediately; next frame uses SEQ=00; no done pulse.
REQ-037 SEQ wrap: run 256 frames -> frame 257 carries SEQ=00.
